// File: rtl/uart_report_tx.sv
// uart_report_tx: captures the 8-bit event count on each latch pulse,
// converts it to three ASCII decimal digits by repeated subtraction, and
// sends "ddd\r\n" as UART 8N1 on tx. No divider or multiplier is used.
`timescale 1ns/1ps

module uart_report_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       tim025,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy,
    output logic       overrun
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state, state_nxt;
    logic             tim_d;
    logic [7:0]       rem, rem_nxt;
    logic [3:0]       h, h_nxt;
    logic [3:0]       t, t_nxt;
    logic [2:0]       char_idx, char_nxt;
    logic [2:0]       bit_idx, bit_nxt;
    logic [CNT_W-1:0] bit_cnt, cnt_nxt;
    logic             busy_nxt;
    logic             ovr_nxt;
    logic             tx_nxt;
    logic [7:0]       cur_char;
    logic             bit_end;

    assign bit_end = (bit_cnt == CNT_LAST);

    // Select the character being framed from the digit registers.
    always_comb begin
        cur_char = 8'h0A;
        case (char_idx)
            3'd0:    cur_char = 8'h30 + {4'b0000, h};
            3'd1:    cur_char = 8'h30 + {4'b0000, t};
            3'd2:    cur_char = 8'h30 + rem;
            3'd3:    cur_char = 8'h0D;
            default: cur_char = 8'h0A;
        endcase
    end

    // Next-state, conversion, framing and flag logic.
    // tx_nxt is derived from the current state, so the registered tx lags the
    // state by one cycle; every bit still lasts exactly CLKS_PER_BIT cycles.
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        h_nxt     = h;
        t_nxt     = t;
        char_nxt  = char_idx;
        bit_nxt   = bit_idx;
        cnt_nxt   = bit_cnt;
        busy_nxt  = busy;
        ovr_nxt   = overrun;
        tx_nxt    = 1'b1;

        if (tim_d && (state != IDLE)) begin
            ovr_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                if (tim_d) begin
                    rem_nxt   = data_in;
                    h_nxt     = '0;
                    t_nxt     = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (rem >= 8'd100) begin
                    rem_nxt = rem - 8'd100;
                    h_nxt   = h + 4'd1;
                end else if (rem >= 8'd10) begin
                    rem_nxt = rem - 8'd10;
                    t_nxt   = t + 4'd1;
                end else begin
                    char_nxt  = '0;
                    cnt_nxt   = '0;
                    state_nxt = START;
                end
            end
            START: begin
                tx_nxt = 1'b0;
                if (bit_end) begin
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                    state_nxt = DATA;
                end else begin
                    cnt_nxt = bit_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                tx_nxt = cur_char[bit_idx];
                if (bit_end) begin
                    cnt_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = bit_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                tx_nxt = 1'b1;
                if (bit_end) begin
                    cnt_nxt = '0;
                    if (char_idx == 3'd4) begin
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        char_nxt  = char_idx + 3'd1;
                        state_nxt = START;
                    end
                end else begin
                    cnt_nxt = bit_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state    <= IDLE;
            tim_d    <= 1'b0;
            rem      <= '0;
            h        <= '0;
            t        <= '0;
            char_idx <= '0;
            bit_idx  <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_nxt;
            tim_d    <= tim025;
            rem      <= rem_nxt;
            h        <= h_nxt;
            t        <= t_nxt;
            char_idx <= char_nxt;
            bit_idx  <= bit_nxt;
            bit_cnt  <= cnt_nxt;
            busy     <= busy_nxt;
            overrun  <= ovr_nxt;
            tx       <= tx_nxt;
        end
    end

endmodule

// File: tb/tb_uart_report_tx.sv
// Directed bench for uart_report_tx: a UART receiver model decodes tx and
// checks each byte against a queue of expected characters filled at stimulus.
`timescale 1ns/1ps

module tb_uart_report_tx;

    localparam int CPB = 4;
    localparam int SAMPLE0 = CPB + CPB / 2 - 1;

    logic       clk_in  = 1'b0;
    logic       reset   = 1'b0;
    logic       tim025  = 1'b0;
    logic [7:0] data_in = '0;
    logic       tx;
    logic       busy;
    logic       overrun;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];

    uart_report_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_in  (clk_in),
        .reset   (reset),
        .tim025  (tim025),
        .data_in (data_in),
        .tx      (tx),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Receiver model: detect start bit on falling edges of clk, sample mid-bit.
    int         rx_on  = 0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = '0;

    always @(negedge clk_in) begin
        if (reset !== 1'b1) begin
            rx_on = 0;
        end else if (rx_on == 0) begin
            if (tx === 1'b0) begin
                rx_on  = 1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt >= SAMPLE0 && ((rx_cnt - SAMPLE0) % CPB) == 0) begin
                if ((rx_cnt - SAMPLE0) / CPB < 8) begin
                    rx_byte[(rx_cnt - SAMPLE0) / CPB] = tx;
                end else begin
                    rx_on = 0;
                    check("stop_bit", 32'(tx), 32'd1);
                    check("byte_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        check("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic push_report(input int v);
        exp_q.push_back(8'h30 + 8'(v / 100));
        exp_q.push_back(8'h30 + 8'((v % 100) / 10));
        exp_q.push_back(8'h30 + 8'(v % 10));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Pulse tim025 now; return just after the edge where tx first falls.
    task automatic start_report(input int v, input int lat);
        int n;
        push_report(v);
        data_in = 8'(v);
        tim025  = 1'b1;
        @(posedge clk_in);
        #1 tim025 = 1'b0;
        n = 0;
        do begin
            @(posedge clk_in);
            #1;
            n++;
            if (n == 1) check("busy_at_capture", 32'(busy), 32'd1);
        end while (tx !== 1'b0 && n < 40);
        check("start_latency", 32'(n), 32'(lat + 1));
    endtask

    // Wait for busy to fall; n0 = cycles already elapsed since tx fell.
    task automatic finish_report(input int n0);
        int n;
        n = n0;
        while (busy !== 1'b0 && n < 300) begin
            @(posedge clk_in);
            #1;
            n++;
        end
        check("busy_fall_window", 32'(n >= 50 * CPB - 1 && n <= 50 * CPB), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_report(input int v, input int lat);
        start_report(v, lat);
        finish_report(0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        reset = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_in);
            #1;
            check("idle_tx", 32'(tx), 32'd1);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_overrun", 32'(overrun), 32'd0);
        end

        // Main conversions, including 0 and large values
        run_report(123, 5);
        repeat (5) @(posedge clk_in);
        #1;
        run_report(0, 2);
        repeat (3) @(posedge clk_in);
        #1;
        run_report(250, 9);
        repeat (3) @(posedge clk_in);
        #1;

        // Overrun: second pulse mid-report is dropped
        start_report(77, 9);
        repeat (50) @(posedge clk_in);
        #1;
        data_in = 8'd7;
        tim025  = 1'b1;
        @(posedge clk_in);
        #1 tim025 = 1'b0;
        check("overrun_before", 32'(overrun), 32'd0);
        @(posedge clk_in);
        #1;
        check("overrun_set", 32'(overrun), 32'd1);
        finish_report(52);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_in);
            #1;
            check("post_ovr_tx", 32'(tx), 32'd1);
            check("post_ovr_busy", 32'(busy), 32'd0);
        end
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Reset during DATA of the second character
        start_report(98, 11);
        repeat (55) @(posedge clk_in);
        #1 reset = 1'b0;
        @(posedge clk_in);
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        reset = 1'b1;
        exp_q.delete();
        repeat (3) @(posedge clk_in);
        #1;
        run_report(42, 6);
        repeat (3) @(posedge clk_in);
        #1;

        // Back-to-back: pulse one cycle after busy falls
        run_report(200, 4);
        run_report(255, 9);
        check("b2b_overrun", 32'(overrun), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
